// File: rtl/csi_frame_stats.sv
// CSI-2 receiver frame statistics and board status monitor (word_clk domain).
//
// Purpose: measures lines per frame and payload words in the first line,
// counts completed frames, flags inconsistent or truncated lines, and drives
// a heartbeat plus a pulse-stretched frame-activity indicator for LEDs.
//
// Ports:
//   word_clk        sole clock, rising edge
//   areset_n        asynchronous active-low reset
//   in_frame        receiver frame-active level
//   in_line         receiver line-active level
//   payload_enable  one payload word valid this cycle
//   err_clear       synchronous clear of sticky error flags (set wins)
//   stat_lines      line count of last completed frame (saturating)
//   stat_words      payload words in first completed line of last frame
//   stat_frames     completed-frame counter, wraps
//   stat_valid      one-cycle pulse when stat_* update
//   err_len         sticky: a line length differed from the frame's first line
//   err_trunc       sticky: frame ended while a line was active
//   heartbeat       free-running divider MSB
//   frame_act       stretched frame-start indicator
//
// FSM states:
//   IDLE  | waiting for a frame start; line and payload activity ignored
//   FRAME | frame active; lines and payload words are being measured
module csi_frame_stats #(
  parameter int CNT_W     = 16,
  parameter int HB_W      = 23,
  parameter int STRETCH_W = 20
) (
  input  logic             word_clk,
  input  logic             areset_n,
  input  logic             in_frame,
  input  logic             in_line,
  input  logic             payload_enable,
  input  logic             err_clear,
  output logic [CNT_W-1:0] stat_lines,
  output logic [CNT_W-1:0] stat_words,
  output logic [CNT_W-1:0] stat_frames,
  output logic             stat_valid,
  output logic             err_len,
  output logic             err_trunc,
  output logic             heartbeat,
  output logic             frame_act
);

  typedef enum logic {IDLE = 1'b0, FRAME = 1'b1} state_t;

  state_t state_q, state_d;

  logic s_frame, s_line, s_pe;
  logic p_frame, p_line;
  logic frame_rise, frame_fall, line_rise, line_fall;
  logic start_frame, end_frame;
  logic in_frame_st, line_end, len_mismatch;

  logic [CNT_W-1:0]     line_cnt, word_cnt, ref_len;
  logic [CNT_W-1:0]     line_cnt_d, ref_len_d, word_cnt_inc;
  logic                 first_line;
  logic [HB_W-1:0]      hb_cnt;
  logic [STRETCH_W-1:0] stretch_cnt;

  // Input sample stage and one-deep history for edge detection.
  always_ff @(posedge word_clk or negedge areset_n) begin
    if (!areset_n) begin
      s_frame <= 1'b0;
      s_line  <= 1'b0;
      s_pe    <= 1'b0;
      p_frame <= 1'b0;
      p_line  <= 1'b0;
    end else begin
      s_frame <= in_frame;
      s_line  <= in_line;
      s_pe    <= payload_enable;
      p_frame <= s_frame;
      p_line  <= s_line;
    end
  end

  assign frame_rise = s_frame & ~p_frame;
  assign frame_fall = ~s_frame & p_frame;
  assign line_rise  = s_line & ~p_line;
  assign line_fall  = ~s_line & p_line;

  always_ff @(posedge word_clk or negedge areset_n) begin
    if (!areset_n) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    start_frame = 1'b0;
    end_frame   = 1'b0;
    case (state_q)
      IDLE: begin
        if (frame_rise) begin
          state_d     = FRAME;
          start_frame = 1'b1;
        end
      end
      FRAME: begin
        if (frame_fall) begin
          state_d   = IDLE;
          end_frame = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_frame_st  = (state_q == FRAME);
  assign line_end     = in_frame_st & line_fall;
  assign len_mismatch = line_end & ~first_line & (word_cnt != ref_len);

  // Next-cycle views of line count and reference length, so a line that ends
  // (or starts) in the same cycle as the frame is reflected in latched stats.
  assign ref_len_d    = (line_end & first_line) ? word_cnt : ref_len;
  assign line_cnt_d   = (in_frame_st & line_rise & ~(&line_cnt)) ?
                        line_cnt + CNT_W'(1) : line_cnt;
  assign word_cnt_inc = (&word_cnt) ? word_cnt : word_cnt + CNT_W'(1);

  always_ff @(posedge word_clk or negedge areset_n) begin
    if (!areset_n) begin
      line_cnt   <= '0;
      word_cnt   <= '0;
      ref_len    <= '0;
      first_line <= 1'b0;
    end else if (start_frame) begin
      line_cnt   <= '0;
      word_cnt   <= '0;
      ref_len    <= '0;
      first_line <= 1'b1;
    end else if (in_frame_st) begin
      line_cnt <= line_cnt_d;
      ref_len  <= ref_len_d;
      if (line_end) first_line <= 1'b0;
      // A word arriving on the line's first cycle counts toward that line.
      if (line_rise)           word_cnt <= CNT_W'(s_pe);
      else if (s_line && s_pe) word_cnt <= word_cnt_inc;
    end
  end

  always_ff @(posedge word_clk or negedge areset_n) begin
    if (!areset_n) begin
      stat_lines  <= '0;
      stat_words  <= '0;
      stat_frames <= '0;
      stat_valid  <= 1'b0;
    end else begin
      stat_valid <= end_frame;
      if (end_frame) begin
        stat_lines  <= line_cnt_d;
        stat_words  <= ref_len_d;
        stat_frames <= stat_frames + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge word_clk or negedge areset_n) begin
    if (!areset_n) begin
      err_len   <= 1'b0;
      err_trunc <= 1'b0;
    end else begin
      if (len_mismatch)   err_len <= 1'b1;
      else if (err_clear) err_len <= 1'b0;
      // A line falling together with the frame is a clean end, not truncation.
      if (end_frame && s_line) err_trunc <= 1'b1;
      else if (err_clear)      err_trunc <= 1'b0;
    end
  end

  always_ff @(posedge word_clk or negedge areset_n) begin
    if (!areset_n) hb_cnt <= '0;
    else           hb_cnt <= hb_cnt + HB_W'(1);
  end

  assign heartbeat = hb_cnt[HB_W-1];

  always_ff @(posedge word_clk or negedge areset_n) begin
    if (!areset_n)                stretch_cnt <= '0;
    else if (frame_rise)          stretch_cnt <= '1;
    else if (stretch_cnt != '0)   stretch_cnt <= stretch_cnt - STRETCH_W'(1);
  end

  assign frame_act = (stretch_cnt != '0);

endmodule

// File: tb/tb_csi_frame_stats.sv
module tb_csi_frame_stats;
  localparam int CNT_W = 4;
  localparam int MAXC  = 15;

  logic word_clk = 1'b0;
  logic areset_n = 1'b0;
  logic in_frame = 1'b0, in_line = 1'b0, payload_enable = 1'b0, err_clear = 1'b0;
  logic [CNT_W-1:0] stat_lines, stat_words, stat_frames;
  logic stat_valid, err_len, err_trunc, heartbeat, frame_act;

  int tests = 0;
  int fails = 0;

  // Frame description for the next run_frame call: payload words per line.
  int lens_q[$];

  // Reference state.
  int m_frames = 0, m_lines = 0, m_words = 0;
  bit m_err_len = 1'b0, m_err_trunc = 1'b0;

  always #5 word_clk = ~word_clk;

  csi_frame_stats #(.CNT_W(CNT_W), .HB_W(3), .STRETCH_W(3)) dut (
    .word_clk(word_clk), .areset_n(areset_n), .in_frame(in_frame),
    .in_line(in_line), .payload_enable(payload_enable), .err_clear(err_clear),
    .stat_lines(stat_lines), .stat_words(stat_words), .stat_frames(stat_frames),
    .stat_valid(stat_valid), .err_len(err_len), .err_trunc(err_trunc),
    .heartbeat(heartbeat), .frame_act(frame_act)
  );

  // Drives one frame from lens_q and checks the latched statistics.
  // trunc: frame falls while the last (partial) line is still active.
  // simul: last line and frame fall together.  b2b: next frame rises one
  // cycle after the fall.  clr_line: err_clear lands on that line's end.
  task automatic run_frame(input bit trunc, input bit simul, input bit b2b,
                           input int clr_line, input string name);
    int n, done, sent, lat, pulses, ng, first, exp_lines;
    bit pe, set;
    logic [CNT_W-1:0] g_lines, g_words, g_frames;
    logic g_el, g_et;
    n = lens_q.size();
    g_lines = 'x; g_words = 'x; g_frames = 'x; g_el = 1'bx; g_et = 1'bx;
    in_frame = 1'b1; in_line = 1'b0; payload_enable = 1'b0;
    repeat (2) @(negedge word_clk);
    for (int i = 0; i < n; i++) begin
      sent = 0;
      while (sent < lens_q[i]) begin
        pe = ($urandom_range(0, 2) != 0);
        in_line = 1'b1; payload_enable = pe;
        @(negedge word_clk);
        if (pe) sent++;
      end
      if (i == n - 1 && (trunc || simul)) break;
      in_line = 1'b0;
      ng = 2 + $urandom_range(0, 2);
      for (int g = 0; g < ng; g++) begin
        payload_enable = $urandom_range(0, 1);
        err_clear = (g == 1 && i == clr_line);
        @(negedge word_clk);
      end
      err_clear = 1'b0;
    end
    in_frame = 1'b0; payload_enable = 1'b0;
    in_line = trunc;
    pulses = 0; lat = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge word_clk);
      if (stat_valid) begin
        pulses++; lat = k;
        g_lines = stat_lines; g_words = stat_words; g_frames = stat_frames;
        g_el = err_len; g_et = err_trunc;
      end
      if (k == 1) begin
        in_line = 1'b0;
        if (b2b) in_frame = 1'b1;
      end
    end

    done  = trunc ? n - 1 : n;
    first = (done > 0) ? lens_q[0] : 0;
    for (int i = 0; i < done; i++) begin
      set = (i > 0) && (lens_q[i] != lens_q[0]);
      if (set) m_err_len = 1'b1;
      else if (i == clr_line) m_err_len = 1'b0;
      if (i == clr_line) m_err_trunc = 1'b0;
    end
    if (trunc) m_err_trunc = 1'b1;
    exp_lines = (n > MAXC) ? MAXC : n;
    m_frames  = (m_frames + 1) % 16;
    m_lines   = exp_lines;
    m_words   = first;

    tests++; if (pulses !== 1) begin fails++;
      $display("FAIL %s pulses: got %0d expected 1", name, pulses); end
    tests++; if (lat !== 2) begin fails++;
      $display("FAIL %s latency: got %0d expected 2", name, lat); end
    tests++; if (g_lines !== CNT_W'(exp_lines)) begin fails++;
      $display("FAIL %s stat_lines: got %0d expected %0d", name, g_lines, exp_lines); end
    tests++; if (g_words !== CNT_W'(first)) begin fails++;
      $display("FAIL %s stat_words: got %0d expected %0d", name, g_words, first); end
    tests++; if (g_frames !== CNT_W'(m_frames)) begin fails++;
      $display("FAIL %s stat_frames: got %0d expected %0d", name, g_frames, m_frames); end
    tests++; if (g_el !== m_err_len) begin fails++;
      $display("FAIL %s err_len: got %b expected %b", name, g_el, m_err_len); end
    tests++; if (g_et !== m_err_trunc) begin fails++;
      $display("FAIL %s err_trunc: got %b expected %b", name, g_et, m_err_trunc); end
  endtask

  task automatic pulse_clear(input string name);
    err_clear = 1'b1;
    @(negedge word_clk);
    err_clear = 1'b0;
    m_err_len = 1'b0; m_err_trunc = 1'b0;
    tests++; if ({err_len, err_trunc} !== 2'b00) begin fails++;
      $display("FAIL %s flags: got %b%b expected 00", name, err_len, err_trunc); end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge word_clk);
    tests++;
    if ({stat_lines, stat_words, stat_frames, stat_valid, err_len, err_trunc,
         heartbeat, frame_act} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got %h/%h/%h v%b el%b et%b hb%b fa%b expected all 0",
               stat_lines, stat_words, stat_frames, stat_valid, err_len, err_trunc,
               heartbeat, frame_act);
    end
    areset_n = 1'b1;
    @(negedge word_clk);
  endtask

  task automatic test_clean;
    lens_q = '{10, 10, 10, 10};
    run_frame(0, 0, 0, -1, "clean");
  endtask

  task automatic test_reset_mid;
    int seen;
    // Leave sticky state behind so the reset has something to clear.
    lens_q = '{3, 4};
    run_frame(1, 0, 0, -1, "pre_reset");
    in_frame = 1'b1;
    repeat (2) @(negedge word_clk);
    in_line = 1'b1; payload_enable = 1'b1;
    repeat (5) @(negedge word_clk);
    #2 areset_n = 1'b0;
    #1;
    tests++;
    if ({stat_lines, stat_words, stat_frames, stat_valid, err_len, err_trunc,
         heartbeat, frame_act} !== '0) begin
      fails++;
      $display("FAIL reset_mid_outputs: got %h/%h/%h v%b el%b et%b hb%b fa%b expected all 0",
               stat_lines, stat_words, stat_frames, stat_valid, err_len, err_trunc,
               heartbeat, frame_act);
    end
    in_frame = 1'b0; in_line = 1'b0; payload_enable = 1'b0;
    @(negedge word_clk);
    areset_n = 1'b1;
    m_frames = 0; m_lines = 0; m_words = 0; m_err_len = 1'b0; m_err_trunc = 1'b0;
    seen = 0;
    repeat (10) begin
      @(negedge word_clk);
      if (stat_valid) seen++;
    end
    tests++; if (seen !== 0) begin fails++;
      $display("FAIL reset_mid_no_valid: got %0d pulses expected 0", seen); end
    lens_q = '{6, 6, 6};
    run_frame(0, 0, 0, -1, "after_reset");
  endtask

  task automatic test_len_err;
    lens_q = '{10, 10, 9, 10};
    run_frame(0, 0, 0, -1, "len_mismatch");
    lens_q = '{10, 10, 10, 10};
    run_frame(0, 0, 0, -1, "len_sticky");
    pulse_clear("len_clear");
    lens_q = '{10, 10, 9, 10};
    run_frame(0, 0, 0, 2, "len_set_wins");
    lens_q = '{7, 7, 7};
    run_frame(0, 0, 0, 1, "len_inframe_clear");
  endtask

  task automatic test_trunc;
    lens_q = '{10, 10, 10, 6};
    run_frame(1, 0, 0, -1, "trunc");
    pulse_clear("trunc_clear");
    lens_q = '{8, 8, 7};
    run_frame(0, 1, 0, -1, "simul_fall");
    pulse_clear("simul_clear");
    lens_q = '{5};
    run_frame(0, 1, 0, -1, "simul_single");
    lens_q = '{4};
    run_frame(1, 0, 0, -1, "trunc_only_partial");
    pulse_clear("trunc_only_clear");
  endtask

  task automatic test_idle;
    int seen;
    seen = 0;
    in_frame = 1'b0;
    for (int i = 0; i < 30; i++) begin
      in_line = $urandom_range(0, 1);
      payload_enable = $urandom_range(0, 1);
      @(negedge word_clk);
      if (stat_valid) seen++;
    end
    in_line = 1'b0; payload_enable = 1'b0;
    repeat (3) @(negedge word_clk);
    if (stat_valid) seen++;
    tests++; if (seen !== 0) begin fails++;
      $display("FAIL idle_no_valid: got %0d pulses expected 0", seen); end
    tests++;
    if ({stat_lines, stat_words, stat_frames} !==
        {CNT_W'(m_lines), CNT_W'(m_words), CNT_W'(m_frames)}) begin
      fails++;
      $display("FAIL idle_stats: got %0d/%0d/%0d expected %0d/%0d/%0d",
               stat_lines, stat_words, stat_frames, m_lines, m_words, m_frames);
    end
    tests++; if ({err_len, err_trunc} !== {m_err_len, m_err_trunc}) begin fails++;
      $display("FAIL idle_flags: got %b%b expected %b%b", err_len, err_trunc,
               m_err_len, m_err_trunc); end
  endtask

  task automatic test_saturate;
    lens_q = {};
    for (int i = 0; i < 20; i++) lens_q.push_back(3);
    run_frame(0, 0, 0, -1, "saturate");
  endtask

  task automatic test_back_to_back;
    lens_q = '{5, 5};
    run_frame(0, 0, 1, -1, "b2b_first");
    lens_q = '{9, 9, 9};
    run_frame(0, 0, 0, -1, "b2b_second");
  endtask

  task automatic test_random_wrap;
    int n, mode;
    bit b2b;
    for (int f = 0; f < 17; f++) begin
      n = $urandom_range(1, 5);
      lens_q = {};
      for (int i = 0; i < n; i++) lens_q.push_back($urandom_range(1, 12));
      mode = $urandom_range(0, 2);
      b2b = (f < 16) && ($urandom_range(0, 3) == 0);
      run_frame(mode == 1, mode == 2, b2b, -1, "random");
    end
    in_frame = 1'b0;
    repeat (3) @(negedge word_clk);
  endtask

  task automatic test_heartbeat;
    int last_t, toggles;
    logic prev;
    prev = heartbeat; last_t = -1; toggles = 0;
    for (int t = 0; t < 24; t++) begin
      @(negedge word_clk);
      if (heartbeat !== prev) begin
        if (last_t >= 0) begin
          tests++; if (t - last_t !== 4) begin fails++;
            $display("FAIL heartbeat_period: got %0d expected 4", t - last_t); end
        end
        last_t = t; toggles++;
      end
      prev = heartbeat;
    end
    tests++; if (toggles < 5) begin fails++;
      $display("FAIL heartbeat_toggles: got %0d expected at least 5", toggles); end
  endtask

  task automatic test_stretch;
    int hi, first_hi, last_hi;
    in_frame = 1'b0; in_line = 1'b0; payload_enable = 1'b0;
    repeat (10) @(negedge word_clk);
    // Single trigger.
    in_frame = 1'b1;
    hi = 0; first_hi = -1; last_hi = -1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge word_clk);
      if (frame_act) begin
        hi++; last_hi = k;
        if (first_hi < 0) first_hi = k;
      end
    end
    tests++; if (hi !== 7 || first_hi !== 2) begin fails++;
      $display("FAIL stretch_single: got %0d cycles from %0d expected 7 from 2", hi, first_hi); end
    in_frame = 1'b0;
    repeat (10) @(negedge word_clk);
    // Retrigger part-way through the stretch.
    in_frame = 1'b1;
    hi = 0; first_hi = -1; last_hi = -1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge word_clk);
      if (frame_act) begin
        hi++; last_hi = k;
        if (first_hi < 0) first_hi = k;
      end
      if (k == 2) in_frame = 1'b0;
      if (k == 4) in_frame = 1'b1;
    end
    tests++; if (first_hi !== 2 || last_hi !== 12 || hi !== 11) begin fails++;
      $display("FAIL stretch_retrigger: got first %0d last %0d count %0d expected 2 12 11",
               first_hi, last_hi, hi); end
    in_frame = 1'b0;
    repeat (4) @(negedge word_clk);
    // Three empty frames completed here.
    m_frames = (m_frames + 3) % 16; m_lines = 0; m_words = 0;
    tests++; if ({stat_lines, stat_words, stat_frames} !==
                 {CNT_W'(0), CNT_W'(0), CNT_W'(m_frames)}) begin fails++;
      $display("FAIL stretch_empty_frames: got %0d/%0d/%0d expected 0/0/%0d",
               stat_lines, stat_words, stat_frames, m_frames); end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_reset_mid();
    test_len_err();
    test_trunc();
    test_idle();
    test_saturate();
    test_back_to_back();
    test_heartbeat();
    test_stretch();
    test_random_wrap();
    test_idle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
